piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per parallel word; legal values are 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted first and 0 = LSB shifted first.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a word; a transfer occurs on the edge where in_valid && in_ready.
REQ-008 The block SHALL have port sout, output, 1 bit: serial bit stream to the downstream sequence detector.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-010 The block SHALL have port sout_last, output, 1 bit: the current bit is the final bit of its word.
REQ-011 The block SHALL have port word_cnt, output, 16 bits: count of fully shifted words.

Function
REQ-012 The block SHALL contain a holding register (hold, hold_full), a shift register sreg[WIDTH], a bit counter cnt (0..WIDTH-1) and an FSM with states IDLE and SHIFT.
REQ-013 in_ready SHALL equal !hold_full, driven from a register with no combinational path from in_valid.
REQ-014 On a transfer edge, in_data SHALL be captured into hold and hold_full SHALL be set.
REQ-015 In IDLE with hold_full=1, the next edge SHALL load sreg<=hold, clear hold_full, set cnt<=0 and go to SHIFT; in IDLE with hold_full=0, the FSM SHALL stay in IDLE.
REQ-016 In SHIFT with cnt<WIDTH-1, each edge SHALL shift sreg by one bit toward the output end and increment cnt.
REQ-017 In SHIFT with cnt==WIDTH-1 and hold_full=1, the edge SHALL reload sreg from hold, clear hold_full, set cnt<=0 and stay in SHIFT (gap-free streaming).
REQ-018 In SHIFT with cnt==WIDTH-1 and hold_full=0, the edge SHALL go to IDLE.
REQ-019 sout SHALL be sreg[WIDTH-1] when MSB_FIRST=1 and sreg[0] when MSB_FIRST=0; sout SHALL be 0 when not in SHIFT.
REQ-020 sout_valid SHALL be 1 exactly when state==SHIFT.
REQ-021 sout_last SHALL be 1 exactly when state==SHIFT && cnt==WIDTH-1.
REQ-022 Latency SHALL be fixed: for a transfer on edge N into an idle block, the first bit SHALL be valid in the cycle after edge N+1, and the last bit in the cycle after edge N+WIDTH.
REQ-023 word_cnt SHALL increment on each edge where sout_last=1 and SHALL wrap from 16'hFFFF to 0.
REQ-024 A transfer and a hold-to-sreg load SHALL never coincide, because in_ready=0 whenever hold_full=1; in_valid while in_ready=0 SHALL be ignored and in_data need not be held stable.
REQ-025 Sustained input SHALL yield an unbroken stream: sout_valid stays 1 across word boundaries when each next word is accepted at least one cycle before the current sout_last.

Reset
REQ-026 While rst=1 on an edge, the block SHALL set state=IDLE, hold_full=0, cnt=0, sreg=0 and word_cnt=0, so that after that edge sout=0, sout_valid=0, sout_last=0 and in_ready=1.
REQ-027 rst SHALL override all other activity, including a transfer and a mid-word shift, on the same edge.
REQ-028 A partially shifted word and any held word SHALL be discarded on reset and never emitted.

Verification
REQ-029 Single word test: with WIDTH=8 and MSB_FIRST=1, send 8'hD0 on edge N -> sout = 1,1,0,1,0,0,0,0 in cycles after edges N+1..N+8; sout_last only on the 8th bit; word_cnt=1 afterwards.
REQ-030 LSB-first test: with MSB_FIRST=0, send 8'h0B -> sout = 1,1,0,1,0,0,0,0; the downstream 1101 detector asserts once.
REQ-031 Back-to-back test: send 8'hDD then 8'hD0 with in_valid held -> 16 consecutive sout_valid=1 cycles with no gap; in_ready=0 while hold_full=1; sout_last on bits 8 and 16; word_cnt=2.
REQ-032 Backpressure test: hold in_valid=1 with a new word every cycle -> exactly one transfer per 8 cycles in steady state; no word lost or duplicated, checked with a scoreboard.
REQ-033 Reset mid-word test: assert rst after 3 bits of 8'hFF with 8'hAA held -> sout_valid=0 next cycle; neither remaining bits nor 8'hAA emitted; word_cnt=0; in_ready=1.
REQ-034 Counter wrap test: preload 65535 words (or force word_cnt=16'hFFFF), send one more word -> word_cnt=0 after its sout_last edge.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding register so that
// back-to-back words stream out with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic [15:0]      word_cnt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdFull;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_wordCnt;

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_outBit;
  logic [WIDTH-1:0] w_sregShifted;

  // A load only happens while the hold is full, and a transfer only while it
  // is empty, so the two can never collide on one edge.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    case (r_state)
      IDLE: begin
        if (r_holdFull) begin
          w_load      = 1'b1;
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != LAST_CNT) begin
          w_shift = 1'b1;
        end else if (r_holdFull) begin
          w_load = 1'b1;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_sregShifted = r_sreg;
    w_outBit      = 1'b0;
    if (MSB_FIRST) begin
      w_sregShifted = {r_sreg[WIDTH-2:0], 1'b0};
      w_outBit      = r_sreg[WIDTH-1];
    end else begin
      w_sregShifted = {1'b0, r_sreg[WIDTH-1:1]};
      w_outBit      = r_sreg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_wordCnt  <= '0;
    end else begin
      if (in_valid && !r_holdFull) begin
        r_hold     <= in_data;
        r_holdFull <= 1'b1;
      end else if (w_load) begin
        r_holdFull <= 1'b0;
      end

      if (w_load) begin
        r_sreg <= r_hold;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_sreg <= w_sregShifted;
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_last) begin
        r_wordCnt <= r_wordCnt + 16'd1;
      end
    end
  end

  assign in_ready   = !r_holdFull;
  assign sout_valid = (r_state == SHIFT);
  assign sout       = (r_state == SHIFT) && w_outBit;
  assign sout_last  = w_last;
  assign word_cnt   = r_wordCnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance
// share stimulus; accepted words are expanded into expected bit streams.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] inData = '0;
  logic             inValid = 1'b0;
  logic             inReady [2];
  logic             sout [2];
  logic             soutValid [2];
  logic             soutLast [2];
  logic [15:0]      wordCnt [2];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady[0]), .sout(sout[0]), .sout_valid(soutValid[0]),
    .sout_last(soutLast[0]), .word_cnt(wordCnt[0])
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady[1]), .sout(sout[1]), .sout_valid(soutValid[1]),
    .sout_last(soutLast[1]), .word_cnt(wordCnt[1])
  );

  typedef struct packed {
    logic b;
    logic last;
    logic first;
  } exp_t;

  exp_t        expQ [2][$];
  int          pending [2] = '{0, 0};
  logic [15:0] modelCnt [2] = '{16'd0, 16'd0};
  int          assertCount = 0;
  int          failCount = 0;
  int          runLen = 0;
  int          lastRun = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops one expected bit per valid output cycle, then records any
  // handshake about to happen on the coming edge as a new word of expected bits.
  always @(negedge clk) begin
    exp_t e;
    logic poppedLast;
    for (int i = 0; i < 2; i++) begin
      poppedLast = 1'b0;
      if (soutValid[i] === 1'b1) begin
        if (expQ[i].size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedBit[%0d]: got sout_valid=1, expected no output at %0t", i, $time);
        end else begin
          e = expQ[i].pop_front();
          checkOutput($sformatf("sout[%0d]", i), 32'(sout[i]), 32'(e.b));
          checkOutput($sformatf("soutLast[%0d]", i), 32'(soutLast[i]), 32'(e.last));
          if (e.first) pending[i]--;
          poppedLast = e.last;
        end
      end else begin
        checkOutput($sformatf("idleOutputs[%0d]", i),
                    32'({sout[i], soutLast[i], soutValid[i]}), 32'd0);
      end
      checkOutput($sformatf("wordCnt[%0d]", i), 32'(wordCnt[i]), 32'(modelCnt[i]));
      if (poppedLast) modelCnt[i] = modelCnt[i] + 16'd1;
      checkOutput($sformatf("inReady[%0d]", i), 32'(inReady[i]), 32'(pending[i] == 0));
      if (rst) begin
        expQ[i].delete();
        pending[i] = 0;
        modelCnt[i] = 16'd0;
      end else if (inValid && inReady[i]) begin
        for (int k = 0; k < WIDTH; k++) begin
          e.b     = (i == 0) ? inData[WIDTH-1-k] : inData[k];
          e.last  = (k == WIDTH - 1);
          e.first = (k == 0);
          expQ[i].push_back(e);
        end
        pending[i]++;
      end
    end
    if (soutValid[0] === 1'b1) begin
      runLen++;
    end else begin
      if (runLen > 0) lastRun = runLen;
      runLen = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers a word until accepted; with churn the data changes every refused cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit keepValid,
                               input bit churn);
    bit taken;
    bit ok;
    ok = 1'b0;
    inValid = 1'b1;
    inData = word;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      taken = inReady[0];
      @(posedge clk);
      #1;
      if (taken) begin
        ok = 1'b1;
        break;
      end
      if (churn) inData = WIDTH'($urandom);
    end
    if (!ok) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: got no handshake, expected one within 64 cycles at %0t", $time);
    end
    if (!keepValid) begin
      inValid = 1'b0;
      inData = WIDTH'($urandom);
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (expQ[0].size() == 0 && expQ[1].size() == 0 && !soutValid[0] && !soutValid[1]) begin
        idle = 1'b1;
        break;
      end
      tick(1);
    end
    if (!idle) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL idleTimeout: got output still busy, expected idle within 200 cycles at %0t", $time);
    end
    tick(2);
  endtask

  initial begin
    time tPrev;
    time tNow;
    tPrev = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    checkOutput("resetInReady", 32'(inReady[0]), 32'd1);
    checkOutput("resetSoutValid", 32'(soutValid[0]), 32'd0);
    checkOutput("resetWordCnt", 32'(wordCnt[0]), 32'd0);

    // Single word: first bit one cycle after the load edge, last bit 7 later.
    applyStimulus(8'hD0, 1'b0, 1'b0);
    checkOutput("latencyEarly", 32'(soutValid[0]), 32'd0);
    tick(1);
    checkOutput("latencyFirstValid", 32'(soutValid[0]), 32'd1);
    checkOutput("latencyFirstBit", 32'(sout[0]), 32'd1);
    checkOutput("latencyFirstLast", 32'(soutLast[0]), 32'd0);
    tick(7);
    checkOutput("latencyLastFlag", 32'(soutLast[0]), 32'd1);
    tick(1);
    checkOutput("latencyDone", 32'(soutValid[0]), 32'd0);
    checkOutput("singleWordCnt", 32'(wordCnt[0]), 32'd1);
    waitIdle();

    applyStimulus(8'h0B, 1'b0, 1'b0);
    waitIdle();

    applyStimulus(8'hDD, 1'b1, 1'b0);
    applyStimulus(8'hD0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("backToBackRun", 32'(lastRun), 32'd16);
    checkOutput("backToBackWordCnt", 32'(wordCnt[0]), 32'd4);

    // Sustained input: after the first two words one acceptance every WIDTH cycles.
    for (int w = 0; w < 12; w++) begin
      applyStimulus(WIDTH'($urandom), (w != 11), 1'b1);
      tNow = $time;
      if (w >= 2) checkOutput($sformatf("throughputGap%0d", w), 32'((tNow - tPrev) / 10), 32'(WIDTH));
      tPrev = tNow;
    end
    waitIdle();
    checkOutput("streamRun", 32'(lastRun), 32'(12 * WIDTH));

    // Reset after three bits of 8'hFF with 8'hAA held.
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    tick(1);
    rst = 1'b1;
    inValid = 1'b1;
    inData = WIDTH'($urandom);
    tick(1);
    rst = 1'b0;
    inValid = 1'b0;
    checkOutput("midResetSoutValid", 32'(soutValid[0]), 32'd0);
    checkOutput("midResetInReady", 32'(inReady[0]), 32'd1);
    checkOutput("midResetWordCnt", 32'(wordCnt[0]), 32'd0);
    tick(20);
    checkOutput("midResetQuiet", 32'(soutValid[0]), 32'd0);

    // A reset coinciding with an offered word must swallow it.
    rst = 1'b1;
    inValid = 1'b1;
    inData = 8'h5A;
    tick(1);
    rst = 1'b0;
    inValid = 1'b0;
    tick(12);
    checkOutput("resetTransferDropped", 32'({soutValid[1], soutValid[0]}), 32'd0);

    // Counter wrap.
    force dut0.r_wordCnt = 16'hFFFF;
    force dut1.r_wordCnt = 16'hFFFF;
    modelCnt[0] = 16'hFFFF;
    modelCnt[1] = 16'hFFFF;
    tick(1);
    release dut0.r_wordCnt;
    release dut1.r_wordCnt;
    tick(1);
    checkOutput("preWrapCnt", 32'(wordCnt[0]), 32'hFFFF);
    applyStimulus(WIDTH'($urandom), 1'b0, 1'b0);
    waitIdle();
    checkOutput("wrapCnt0", 32'(wordCnt[0]), 32'd0);
    checkOutput("wrapCnt1", 32'(wordCnt[1]), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 150; n++) begin
      tick($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    inValid = 1'b0;
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
